// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues req/ack word reads to
// instruction memory and buffers up to two instructions for the decoder.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         op,
    output logic [ADDR_W-1:0]  pc_out
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic [ADDR_W-1:0]   r_pending_pc;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic [1:0]          r_count;
    logic                r_head;
    logic [ADDR_W-1:0]   r_fifo_addr  [2];
    logic [INSTR_W-1:0]  r_fifo_instr [2];

    logic                w_pop;
    logic                w_push;
    logic [1:0]          w_count_next;
    logic                w_fits;
    logic                w_wr_idx;
    logic [ADDR_W-1:0]   w_addr_inc;

    assign w_pop        = (r_count != 2'd0) && instr_ready && !redirect;
    assign w_push       = (r_state == S_REQ) && imem_ack && !redirect;
    assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};
    // Only keep a request in flight if its data is guaranteed a free slot.
    assign w_fits       = (w_count_next <= 2'd1);
    assign w_wr_idx     = r_head ^ r_count[0];
    assign w_addr_inc   = r_imem_addr + ADDR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_pending_pc <= RESET_PC;
            r_imem_addr  <= RESET_PC;
            r_count      <= 2'd0;
            r_head       <= 1'b0;
        end else begin
            r_count <= redirect ? 2'd0 : w_count_next;
            if (w_pop)
                r_head <= ~r_head;

            case (r_state)
                S_IDLE: begin
                    if (redirect) begin
                        r_fetch_pc <= redirect_pc;
                    end else if (w_fits) begin
                        r_state     <= S_REQ;
                        r_imem_addr <= r_fetch_pc;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        if (imem_ack) begin
                            r_fetch_pc <= redirect_pc;
                            r_state    <= S_IDLE;
                        end else begin
                            // Memory still owes us a beat; wait it out and drop it.
                            r_pending_pc <= redirect_pc;
                            r_state      <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_fetch_pc <= w_addr_inc;
                        if (w_fits)
                            r_imem_addr <= w_addr_inc;
                        else
                            r_state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        r_fetch_pc <= redirect ? redirect_pc : r_pending_pc;
                        r_state    <= S_IDLE;
                    end else if (redirect) begin
                        r_pending_pc <= redirect_pc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[w_wr_idx]  <= r_imem_addr;
            r_fifo_instr[w_wr_idx] <= imem_rdata;
        end
    end

    assign imem_req    = (r_state != S_IDLE);
    assign imem_addr   = r_imem_addr;
    assign instr_valid = (r_count != 2'd0);
    assign instr       = instr_valid ? r_fifo_instr[r_head] : '0;
    assign pc_out      = instr_valid ? r_fifo_addr[r_head]  : '0;
    assign op          = instr[INSTR_W-1 -: 4];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory model with configurable wait states,
// scoreboard of expected {addr, instr} deliveries, and cycle-exact checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [15:0] pc_out;

    logic        w_req, w_ack, w_valid;
    logic [15:0] w_addr, w_rdata, w_instr, w_pc_out;
    logic [3:0]  w_op;

    int checks = 0;
    int failures = 0;
    int wait_cfg = 0;
    int wcnt = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] memf(input logic [15:0] a);
        if (a == 16'h0000) return 16'h1234;
        if (a == 16'h0001) return 16'h5678;
        return {~a[3:0], a[11:0]};
    endfunction

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .op(op), .pc_out(pc_out)
    );

    // Second instance exercises the PC wrap with a zero-wait memory.
    assign w_ack   = w_req;
    assign w_rdata = memf(w_addr);

    fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF)) dut_w (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(w_valid), .instr_ready(instr_ready),
        .instr(w_instr), .op(w_op), .pc_out(w_pc_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        #3;
    endtask

    task automatic push_exp(input logic [15:0] a);
        exp_t e;
        e.addr = a;
        e.data = memf(a);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        adv();
        reset = 1'b1;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        wait_cfg = 0;
        adv();
        reset = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},  {16'd0, imem_addr},   32'd0);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, {16'd0, instr},       32'd0);
        chk({tag, "_op"},    {28'd0, op},          32'd0);
        chk({tag, "_pc"},    {16'd0, pc_out},      32'd0);
    endtask

    task automatic run_drain(input bit second);
        logic [15:0] tgt;
        tgt = second ? 16'h00C0 : 16'h0080;
        do_reset();
        instr_ready = 1'b1;
        for (int a = 0; a < 5; a++) push_exp(16'(a));
        push_exp(tgt);
        push_exp(tgt + 16'd1);
        repeat (6) adv();
        wait_cfg = 3;
        adv();
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        smp();
        chk("drain_c7_req", {31'd0, imem_req}, 32'd1);
        chk("drain_c7_addr", {16'd0, imem_addr}, 32'h5);
        adv();
        redirect = second;
        redirect_pc = 16'h00C0;
        smp();
        chk("drain_c8_req", {31'd0, imem_req}, 32'd1);
        chk("drain_c8_addr", {16'd0, imem_addr}, 32'h5);
        chk("drain_c8_valid", {31'd0, instr_valid}, 32'd0);
        adv();
        redirect = 1'b0;
        smp();
        chk("drain_c9_addr", {16'd0, imem_addr}, 32'h5);
        adv();
        wait_cfg = 0;
        smp();
        chk("drain_c10_req", {31'd0, imem_req}, 32'd0);
        adv();
        smp();
        chk("drain_c11_req", {31'd0, imem_req}, 32'd1);
        chk("drain_c11_addr", {16'd0, imem_addr}, {16'd0, tgt});
        repeat (3) adv();
        instr_ready = 1'b0;
        smp();
        chk("drain_sb_empty", sb.size(), 32'd0);
    endtask

    // Memory model: acks after wait_cfg wait cycles per request.
    initial begin
        forever begin
            @(negedge clk);
            if (reset || !imem_req) begin
                imem_ack = 1'b0;
                wcnt = 0;
            end else if (wcnt >= wait_cfg) begin
                imem_ack = 1'b1;
                imem_rdata = memf(imem_addr);
                wcnt = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end
    end

    // Scoreboard: every accepted head must be the next expected instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid && instr_ready && !redirect) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL sb_unexpected observed pc=0x%0h instr=0x%0h expected=none", pc_out, instr);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_pc", {16'd0, pc_out}, {16'd0, e.addr});
                    chk("sb_instr", {16'd0, instr}, {16'd0, e.data});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("rst");

        // Zero-wait streaming, plus FFFF -> 0000 wrap on the second instance.
        for (int a = 0; a < 6; a++) push_exp(16'(a));
        reset = 1'b0;
        instr_ready = 1'b1;
        smp();
        chk("c0_req", {31'd0, imem_req}, 32'd0);
        adv();
        smp();
        chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_addr", {16'd0, imem_addr}, 32'h0);
        chk("wrap_c1_addr", {16'd0, w_addr}, 32'hFFFF);
        adv();
        smp();
        chk("c2_valid", {31'd0, instr_valid}, 32'd1);
        chk("c2_op", {28'd0, op}, 32'h1);
        chk("c2_pc", {16'd0, pc_out}, 32'h0);
        chk("wrap_c2_pc", {16'd0, w_pc_out}, 32'hFFFF);
        chk("wrap_c2_addr", {16'd0, w_addr}, 32'h0);
        adv();
        smp();
        chk("c3_op", {28'd0, op}, 32'h5);
        chk("c3_pc", {16'd0, pc_out}, 32'h1);
        chk("wrap_c3_pc", {16'd0, w_pc_out}, 32'h0);
        repeat (5) adv();
        instr_ready = 1'b0;
        smp();
        chk("stream_sb_empty", sb.size(), 32'd0);

        // Backpressure fills the buffer, then release and redirect from IDLE.
        do_reset();
        for (int a = 0; a < 3; a++) push_exp(16'(a));
        repeat (3) adv();
        smp();
        chk("bp_c3_req", {31'd0, imem_req}, 32'd0);
        chk("bp_c3_valid", {31'd0, instr_valid}, 32'd1);
        chk("bp_c3_pc", {16'd0, pc_out}, 32'h0);
        repeat (2) adv();
        smp();
        chk("bp_c5_req", {31'd0, imem_req}, 32'd0);
        chk("bp_c5_instr", {16'd0, instr}, 32'h1234);
        adv();
        instr_ready = 1'b1;
        repeat (3) adv();
        instr_ready = 1'b0;
        smp();
        chk("bp_sb_empty", sb.size(), 32'd0);
        adv();
        smp();
        chk("bp_c10_req", {31'd0, imem_req}, 32'd0);
        chk("bp_c10_pc", {16'd0, pc_out}, 32'h3);
        adv();
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        adv();
        redirect = 1'b0;
        smp();
        chk("redir_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_instr", {16'd0, instr}, 32'd0);
        chk("redir_pc", {16'd0, pc_out}, 32'd0);
        adv();
        smp();
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", {16'd0, imem_addr}, 32'h0040);

        // Redirect while a request is stalled, once and twice during DRAIN.
        run_drain(1'b0);
        run_drain(1'b1);

        // Asynchronous reset with a full buffer.
        do_reset();
        repeat (3) adv();
        smp();
        chk("full_valid", {31'd0, instr_valid}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_zero_outputs("async_rst");
        adv();
        reset = 1'b0;
        adv();
        smp();
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", {16'd0, imem_addr}, 32'h0);
        adv();
        smp();
        chk("restart_pc", {16'd0, pc_out}, 32'h0);
        chk("restart_instr", {16'd0, instr}, 32'h1234);

        adv();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
